// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-master RAM arbiter: FSM states and master indices.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_lock_picker.sv
// Combinational winner selection: M1 lock override first, then round-robin on a tie,
// otherwise the sole requester wins.
module rr_lock_picker
  import ram_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = 8,
  parameter int CNT_W    = $clog2(MAX_LOCK + 1)
) (
  input  logic             m0_req,
  input  logic             m1_req,
  input  logic             m1_lock,
  input  logic [CNT_W-1:0] lock_cnt,
  input  logic             last_grant,
  output logic             any_req,
  output logic             winner
);

  always_comb begin
    any_req = m0_req | m1_req;
    winner  = M0;
    if (m1_req && m1_lock && (lock_cnt < CNT_W'(MAX_LOCK))) begin
      winner = M1;
    end else if (m0_req && m1_req) begin
      // Once the lock saturates, last_grant is M1, so this hands the slot to M0.
      winner = ~last_grant;
    end else if (m1_req) begin
      winner = M1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter for a single-port RAM with combinational read data.
// Each access takes IDLE/RESP -> ACCESS -> RESP, giving one access per two cycles.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 64,
  parameter int MAX_LOCK = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              M0_REQ,
  input  logic              M0_WE,
  input  logic [ADDR_W-1:0] M0_ADDRESS,
  input  logic [DATA_W-1:0] M0_DATA_IN,
  output logic              M0_ACK,
  output logic [DATA_W-1:0] M0_DATA_OUT,
  input  logic              M1_REQ,
  input  logic              M1_WE,
  input  logic [ADDR_W-1:0] M1_ADDRESS,
  input  logic [DATA_W-1:0] M1_DATA_IN,
  input  logic              M1_LOCK,
  output logic              M1_ACK,
  output logic [DATA_W-1:0] M1_DATA_OUT,
  output logic [ADDR_W-1:0] RAM_ADDRESS,
  output logic [DATA_W-1:0] RAM_DATA_IN,
  output logic              RAM_WRITE_ENABLE,
  input  logic [DATA_W-1:0] RAM_DATA_OUT
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  state_t           state;
  logic             cur_master;
  logic             last_grant;
  logic [CNT_W-1:0] lock_cnt;
  logic             any_req;
  logic             winner;

  rr_lock_picker #(
    .MAX_LOCK (MAX_LOCK),
    .CNT_W    (CNT_W)
  ) u_picker (
    .m0_req     (M0_REQ),
    .m1_req     (M1_REQ),
    .m1_lock    (M1_LOCK),
    .lock_cnt   (lock_cnt),
    .last_grant (last_grant),
    .any_req    (any_req),
    .winner     (winner)
  );

  // RAM_WRITE_ENABLE doubles as the captured WE: it is only ever high in ACCESS.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state            <= IDLE;
      cur_master       <= M0;
      last_grant       <= M1;
      lock_cnt         <= '0;
      M0_ACK           <= 1'b0;
      M1_ACK           <= 1'b0;
      M0_DATA_OUT      <= '0;
      M1_DATA_OUT      <= '0;
      RAM_ADDRESS      <= '0;
      RAM_DATA_IN      <= '0;
      RAM_WRITE_ENABLE <= 1'b0;
    end else begin
      M0_ACK           <= 1'b0;
      M1_ACK           <= 1'b0;
      RAM_WRITE_ENABLE <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (any_req) begin
            state      <= ACCESS;
            cur_master <= winner;
            last_grant <= winner;
            if (winner == M1) begin
              RAM_WRITE_ENABLE <= M1_WE;
              RAM_ADDRESS      <= M1_ADDRESS;
              RAM_DATA_IN      <= M1_DATA_IN;
            end else begin
              RAM_WRITE_ENABLE <= M0_WE;
              RAM_ADDRESS      <= M0_ADDRESS;
              RAM_DATA_IN      <= M0_DATA_IN;
            end
          end else begin
            state <= IDLE;
          end
          // Lock run length: counts locked M1 grants, saturating at MAX_LOCK.
          if (!M1_LOCK || (any_req && winner == M0)) begin
            lock_cnt <= '0;
          end else if (any_req && lock_cnt != CNT_W'(MAX_LOCK)) begin
            lock_cnt <= lock_cnt + CNT_W'(1);
          end
        end
        ACCESS: begin
          state <= RESP;
          if (cur_master == M1) begin
            M1_ACK <= 1'b1;
            if (!RAM_WRITE_ENABLE) M1_DATA_OUT <= RAM_DATA_OUT;
          end else begin
            M0_ACK <= 1'b1;
            if (!RAM_WRITE_ENABLE) M0_DATA_OUT <= RAM_DATA_OUT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM (combinational read, clocked write).
module tb_ram_arbiter;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 64;
  localparam int MAX_LOCK = 8;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic              M0_REQ = 1'b0, M0_WE = 1'b0;
  logic [ADDR_W-1:0] M0_ADDRESS = '0;
  logic [DATA_W-1:0] M0_DATA_IN = '0;
  logic              M0_ACK;
  logic [DATA_W-1:0] M0_DATA_OUT;
  logic              M1_REQ = 1'b0, M1_WE = 1'b0, M1_LOCK = 1'b0;
  logic [ADDR_W-1:0] M1_ADDRESS = '0;
  logic [DATA_W-1:0] M1_DATA_IN = '0;
  logic              M1_ACK;
  logic [DATA_W-1:0] M1_DATA_OUT;
  logic [ADDR_W-1:0] RAM_ADDRESS;
  logic [DATA_W-1:0] RAM_DATA_IN;
  logic              RAM_WRITE_ENABLE;
  logic [DATA_W-1:0] RAM_DATA_OUT;

  logic [DATA_W-1:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  ram_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_LOCK (MAX_LOCK)
  ) dut (
    .CLK              (CLK),
    .RESET_N          (RESET_N),
    .M0_REQ           (M0_REQ),
    .M0_WE            (M0_WE),
    .M0_ADDRESS       (M0_ADDRESS),
    .M0_DATA_IN       (M0_DATA_IN),
    .M0_ACK           (M0_ACK),
    .M0_DATA_OUT      (M0_DATA_OUT),
    .M1_REQ           (M1_REQ),
    .M1_WE            (M1_WE),
    .M1_ADDRESS       (M1_ADDRESS),
    .M1_DATA_IN       (M1_DATA_IN),
    .M1_LOCK          (M1_LOCK),
    .M1_ACK           (M1_ACK),
    .M1_DATA_OUT      (M1_DATA_OUT),
    .RAM_ADDRESS      (RAM_ADDRESS),
    .RAM_DATA_IN      (RAM_DATA_IN),
    .RAM_WRITE_ENABLE (RAM_WRITE_ENABLE),
    .RAM_DATA_OUT     (RAM_DATA_OUT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] init_val(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i * 3 + 7);
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = init_val(i);
  end

  always @(posedge CLK) if (RAM_WRITE_ENABLE) mem[RAM_ADDRESS] <= RAM_DATA_IN;
  assign RAM_DATA_OUT = mem[RAM_ADDRESS];

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset;
    RESET_N = 1'b0;
    #2;
    RESET_N = 1'b1;
  endtask

  task automatic test_reset;
    RESET_N = 1'b0;
    #3;
    checks++;
    if ({M0_ACK, M1_ACK, RAM_WRITE_ENABLE} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000", {M0_ACK, M1_ACK, RAM_WRITE_ENABLE});
    end
    checks++;
    if ({RAM_ADDRESS, RAM_DATA_IN} !== '0) begin
      errors++;
      $display("FAIL reset_ram_bus got %h/%h want 0/0", RAM_ADDRESS, RAM_DATA_IN);
    end
    checks++;
    if ({M0_DATA_OUT, M1_DATA_OUT} !== '0) begin
      errors++;
      $display("FAIL reset_data_out got %h/%h want 0/0", M0_DATA_OUT, M1_DATA_OUT);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_write_read;
    M0_REQ = 1'b1; M0_WE = 1'b1; M0_ADDRESS = 10'h005; M0_DATA_IN = 64'h1122334455667788;
    tick();
    checks++;
    if ({RAM_WRITE_ENABLE, RAM_ADDRESS, RAM_DATA_IN} !== {1'b1, 10'h005, 64'h1122334455667788}) begin
      errors++;
      $display("FAIL wr_access got we=%b a=%h d=%h want we=1 a=005 d=1122334455667788",
               RAM_WRITE_ENABLE, RAM_ADDRESS, RAM_DATA_IN);
    end
    M0_REQ = 1'b0;
    tick();
    checks++;
    if ({M0_ACK, M1_ACK, RAM_WRITE_ENABLE} !== 3'b100) begin
      errors++;
      $display("FAIL wr_ack got ack0/ack1/we=%b want 100", {M0_ACK, M1_ACK, RAM_WRITE_ENABLE});
    end
    M0_REQ = 1'b1; M0_WE = 1'b0; M0_DATA_IN = '0;
    tick();
    checks++;
    if ({M0_ACK, RAM_WRITE_ENABLE} !== 2'b00) begin
      errors++;
      $display("FAIL rd_access got ack0/we=%b want 00", {M0_ACK, RAM_WRITE_ENABLE});
    end
    M0_REQ = 1'b0;
    tick();
    checks++;
    if ({M0_ACK, M0_DATA_OUT} !== {1'b1, 64'h1122334455667788}) begin
      errors++;
      $display("FAIL rd_ack got ack=%b d=%h want ack=1 d=1122334455667788", M0_ACK, M0_DATA_OUT);
    end
    tick();
    checks++;
    if ({M0_ACK, RAM_ADDRESS} !== {1'b0, 10'h005}) begin
      errors++;
      $display("FAIL idle_hold got ack=%b a=%h want ack=0 a=005", M0_ACK, RAM_ADDRESS);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0]        exp_ack;
    logic [ADDR_W-1:0] exp_addr;
    pulse_reset();
    M0_REQ = 1'b1; M0_WE = 1'b0; M0_ADDRESS = 10'h020;
    M1_REQ = 1'b1; M1_WE = 1'b0; M1_ADDRESS = 10'h030;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_addr = ((k + 1) % 4 == 2) ? 10'h020 : 10'h030;
      if (k % 2 == 1) begin
        exp_ack = 2'b00;
        checks++;
        if (RAM_ADDRESS !== exp_addr) begin
          errors++;
          $display("FAIL rr_addr_%0d got %h want %h", k, RAM_ADDRESS, exp_addr);
        end
      end else begin
        exp_ack = (k % 4 == 2) ? 2'b10 : 2'b01;
        checks++;
        if ((exp_ack == 2'b10 && M0_DATA_OUT !== init_val(32'h20)) ||
            (exp_ack == 2'b01 && M1_DATA_OUT !== init_val(32'h30))) begin
          errors++;
          $display("FAIL rr_data_%0d got %h/%h", k, M0_DATA_OUT, M1_DATA_OUT);
        end
      end
      checks++;
      if ({M0_ACK, M1_ACK} !== exp_ack) begin
        errors++;
        $display("FAIL rr_ack_%0d got %b want %b", k, {M0_ACK, M1_ACK}, exp_ack);
      end
    end
    M0_REQ = 1'b0; M1_REQ = 1'b0;
    tick(); tick();
  endtask

  task automatic test_lock;
    logic exp_m1 [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int n = 0;
    int m1_done = 0;
    pulse_reset();
    M0_REQ = 1'b1; M0_WE = 1'b0; M0_ADDRESS = 10'h050;
    M1_REQ = 1'b1; M1_WE = 1'b0; M1_ADDRESS = 10'h040; M1_LOCK = 1'b1;
    for (int c = 0; c < 60 && n < 14; c++) begin
      tick();
      if (M0_ACK || M1_ACK) begin
        checks++;
        if ({M0_ACK, M1_ACK} !== {~exp_m1[n], exp_m1[n]}) begin
          errors++;
          $display("FAIL lock_ack_%0d got %b want %b", n, {M0_ACK, M1_ACK}, {~exp_m1[n], exp_m1[n]});
        end
        if (M1_ACK) m1_done++;
        if (m1_done == 12) begin
          M1_REQ = 1'b0; M1_LOCK = 1'b0;
        end
        n++;
      end
    end
    M0_REQ = 1'b0; M1_REQ = 1'b0; M1_LOCK = 1'b0;
    checks++;
    if (n != 14) begin
      errors++;
      $display("FAIL lock_timeout got %0d acks want 14", n);
    end
    tick(); tick();
  endtask

  task automatic test_m1_write;
    int we_cnt = 0;
    int ack_cnt = 0;
    M1_REQ = 1'b1; M1_WE = 1'b1; M1_ADDRESS = 10'h3FF; M1_DATA_IN = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    M1_REQ = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (RAM_WRITE_ENABLE) begin
        we_cnt++;
        checks++;
        if (RAM_ADDRESS !== 10'h3FF) begin
          errors++;
          $display("FAIL m1wr_addr got %h want 3ff", RAM_ADDRESS);
        end
      end
      if (M1_ACK) ack_cnt++;
      tick();
    end
    checks++;
    if (we_cnt != 1 || ack_cnt != 1) begin
      errors++;
      $display("FAIL m1wr_pulse got we=%0d ack=%0d want 1/1", we_cnt, ack_cnt);
    end
    M1_REQ = 1'b1; M1_WE = 1'b0; M1_DATA_IN = '0;
    tick();
    M1_REQ = 1'b0;
    tick();
    checks++;
    if ({M1_ACK, M1_DATA_OUT} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      errors++;
      $display("FAIL m1rd got ack=%b d=%h want ack=1 d=ffffffffffffffff", M1_ACK, M1_DATA_OUT);
    end
    tick();
  endtask

  task automatic test_reset_abort;
    int bad = 0;
    M0_REQ = 1'b1; M0_WE = 1'b1; M0_ADDRESS = 10'h010; M0_DATA_IN = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    checks++;
    if (RAM_WRITE_ENABLE !== 1'b1) begin
      errors++;
      $display("FAIL abort_setup got we=%b want 1", RAM_WRITE_ENABLE);
    end
    M0_REQ = 1'b0; M0_WE = 1'b0;
    RESET_N = 1'b0;
    #1;
    checks++;
    if ({RAM_WRITE_ENABLE, M0_DATA_OUT, M1_DATA_OUT} !== '0) begin
      errors++;
      $display("FAIL abort_async got we=%b d0=%h d1=%h want 0/0/0", RAM_WRITE_ENABLE, M0_DATA_OUT, M1_DATA_OUT);
    end
    #1;
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (M0_ACK || M1_ACK || RAM_WRITE_ENABLE) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_quiet got %0d active cycles want 0", bad);
    end
    M0_REQ = 1'b1; M0_ADDRESS = 10'h010; M0_DATA_IN = '0;
    tick();
    M0_REQ = 1'b0;
    tick();
    checks++;
    if ({M0_ACK, M0_DATA_OUT} !== {1'b1, init_val(32'h10)}) begin
      errors++;
      $display("FAIL abort_readback got ack=%b d=%h want ack=1 d=%h", M0_ACK, M0_DATA_OUT, init_val(32'h10));
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_lock();
    test_m1_write();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 10, RAM word-address width; DATA_W, default 64, data width; MAX_LOCK, default 8, maximum consecutive locked M1 grants.
REQ-002 Ports (name  direction  width  meaning) SHALL be: CLK  in  1  single clock, rising edge; RESET_N  in  1  asynchronous active-low reset.
REQ-003 M0_REQ  in  1  CPU load/store request; M0_WE  in  1  write request; M0_ADDRESS  in  ADDR_W; M0_DATA_IN  in  DATA_W  write data.
REQ-004 M0_ACK  out  1  one-cycle completion pulse; M0_DATA_OUT  out  DATA_W  registered read data.
REQ-005 M1_REQ, M1_WE, M1_ADDRESS, M1_DATA_IN, M1_ACK, M1_DATA_OUT SHALL mirror M0 for the loader/debug port; M1_LOCK  in  1  requests back-to-back M1 ownership.
REQ-006 RAM_ADDRESS  out  ADDR_W; RAM_DATA_IN  out  DATA_W; RAM_WRITE_ENABLE  out  1; RAM_DATA_OUT  in  DATA_W  combinational RAM read data.

Function
REQ-007 FSM states SHALL be IDLE, ACCESS, RESP; arbitration SHALL occur only in IDLE and RESP.
REQ-008 In IDLE/RESP with any REQ high, the winner's WE, ADDRESS, DATA_IN SHALL be captured at the clock edge and state SHALL go to ACCESS; with no REQ, state SHALL go to IDLE.
REQ-009 In ACCESS, RAM_ADDRESS/RAM_DATA_IN SHALL carry captured fields, RAM_WRITE_ENABLE SHALL equal captured WE; state SHALL go to RESP unconditionally.
REQ-010 At the ACCESS-exit edge, a read SHALL load RAM_DATA_OUT into the winner's Mx_DATA_OUT; writes SHALL leave Mx_DATA_OUT unchanged.
REQ-011 In RESP the winner's Mx_ACK SHALL be high for exactly that cycle; latency REQ-sampled to ACK SHALL be 2 cycles; peak throughput one access per 2 cycles.
REQ-012 A requester SHALL hold REQ and fields until its request is captured; REQ high during its own ACK cycle SHALL be treated as a new request.
REQ-013 Outside ACCESS, RAM_WRITE_ENABLE SHALL be 0 and RAM_ADDRESS/RAM_DATA_IN SHALL hold last captured values.
REQ-014 Default policy SHALL be round-robin: on simultaneous requests, the master not granted last wins; a sole requester always wins.
REQ-015 Lock: if M1_LOCK and M1_REQ are high and lock counter < MAX_LOCK, M1 SHALL win regardless of M0_REQ.
REQ-016 Lock counter SHALL increment on each M1 grant with M1_LOCK high, clear on any M0 grant or any arbitration cycle with M1_LOCK low, and saturate at MAX_LOCK.
REQ-017 At counter == MAX_LOCK with M0_REQ high, M0 SHALL win; with M0_REQ low, M1 SHALL still be granted (counter stays saturated).
REQ-018 Request changes during ACCESS SHALL have no effect on the in-flight access.

Reset
REQ-019 RESET_N low SHALL asynchronously force: state IDLE, M0_ACK=M1_ACK=0, M0_DATA_OUT=M1_DATA_OUT=0, RAM_WRITE_ENABLE=0, RAM_ADDRESS=0, RAM_DATA_IN=0, lock counter 0, last-grant=M1 (M0 wins first tie).
REQ-020 Reset asserted during ACCESS SHALL suppress the write (RAM_WRITE_ENABLE low before the edge) and no ACK SHALL be issued for the aborted request.
REQ-021 Release SHALL take effect at the first rising CLK edge after RESET_N rises.

Structure
REQ-022 The FSM state enumeration (IDLE, ACCESS, RESP) and master-index constants (M0=0, M1=1) SHALL reside in a shared package.
REQ-023 Winner selection (round-robin plus lock override) SHALL be one sub-module, rr_lock_picker, combinational with the lock counter held in ram_arbiter.

Verification
REQ-024 M0 write addr 0x005 data 0x1122334455667788, then M0 read 0x005 -> ACK 2 cycles after each REQ, M0_DATA_OUT=0x1122334455667788.
REQ-025 M0 and M1 REQ high same cycle after reset, held continuously -> grants M0, M1, M0, M1; ACKs every 2 cycles alternating.
REQ-026 M1_LOCK=1, M1 streams 12 reads, M0_REQ high throughout -> 8 consecutive M1 ACKs, then M0 ACK, then M1 resumes.
REQ-027 M1 write addr 0x3FF data 0xFFFFFFFFFFFFFFFF -> RAM_WRITE_ENABLE high exactly one cycle with RAM_ADDRESS=0x3FF; readback matches.
REQ-028 RESET_N pulsed low during ACCESS of M0 write to 0x010 -> no ACK, RAM_WRITE_ENABLE never high at an edge, read of 0x010 returns prior content.
